read_bank_arbiter: RTL
======================

// Module: read_bank_arbiter
// PURPOSE
//  Per-bank read arbiter for the multi-bank RAM. N read agents each target one bank
//  per cycle. Detects same-bank collisions for any agent count and grants one agent
//  per bank per cycle, by fixed priority or round-robin. Losers stall until granted.
//  Sits between the read agent ports and the bank read muxes.
// PARAMETERS
//  NB_RDAGENT  4   number of read agents, 1..16
//  NB_BANK     4   number of memory banks, 1..16 (non-power-of-2 allowed)
//  BANK_W      $clog2(NB_BANK) (min 1)  derived, per-agent bank index width
//  ARB_MODE    1   0 = fixed priority (lowest index wins), 1 = round-robin per bank
//  CNT_W       16  width of collision statistics counter
// PORTS
//  aclk         in   1                 clock, rising edge
//  areset       in   1                 asynchronous reset, active-high
//  rd_req       in   NB_RDAGENT        per-agent read request
//  rd_bank      in   NB_RDAGENT*BANK_W agent i bank index at [i*BANK_W +: BANK_W]
//  rd_grant     out  NB_RDAGENT        per-agent grant, same cycle as request
//  collision    out  1                 registered: previous cycle had >=2 reqs on one bank
//  coll_agents  out  NB_RDAGENT        registered: agents denied in previous cycle
//  clear_count  in   1                 synchronous clear of coll_count
//  coll_count   out  CNT_W             saturating count of collision cycles
// BEHAVIOUR
//  Handshake: transfer when rd_req[i] & rd_grant[i]. An agent with rd_req=1 and
//   rd_grant=0 holds rd_req and rd_bank stable until granted.
//  Requests with rd_bank >= NB_BANK are out of range. They are ignored: never
//   granted, never counted, and they do not block other agents.
//  Grant is combinational, zero latency, from inputs and registered per-bank
//   pointers ptr[b] (width $clog2(NB_RDAGENT), min 1).
//  Per bank b, requester set R_b = {i : rd_req[i] & rd_bank[i]==b}. At most one
//   grant per bank. An agent that requests is granted iff it wins its bank.
//  ARB_MODE=0: winner is the lowest i in R_b. ptr is unused and stays 0.
//  ARB_MODE=1: winner is the first i in R_b searching from ptr[b] upward, wrapping
//   NB_RDAGENT-1 -> 0. On any grant on bank b, ptr[b] <= (winner+1) mod NB_RDAGENT.
//   ptr[b] holds when bank b grants nothing.
//  Starvation bound (ARB_MODE=1): a held request is granted within NB_RDAGENT cycles.
//  collision <= OR over b of (|R_b| >= 2). coll_agents <= rd_req & ~rd_grant &
//   in-range. Both update every cycle; a 1-cycle pulse reflects exactly one cycle.
//  NB_RDAGENT=1: collision and coll_agents are constant 0. rd_grant = rd_req & in-range.
//  Reset: while areset=1, rd_grant=0 (combinationally gated), ptr[*]=0, collision=0,
//   coll_agents=0, coll_count=0. Reset mid-operation drops all grants immediately.
//   Agents re-arbitrate from ptr=0 after release.
//  Registered outputs and ptr update on the first rising edge after areset falls.
// CONFIGURATION
//  READ_ARB_STATS_EN defined: coll_count increments by 1 on each edge where the next
//   collision value is 1. It saturates at all-ones and never wraps. clear_count=1
//   forces coll_count to 0 and wins over a simultaneous increment.
//  READ_ARB_STATS_EN undefined: the counter is not built. coll_count is tied to 0
//   and clear_count is ignored. All other behaviour is identical.
// TESTING
//  Defaults (N=4, NB_BANK=4, ARB_MODE=1, STATS on).
//  T1  Reset: areset=1 with rd_req=4'hF -> rd_grant=0, collision=0, coll_count=0.
//  T2  rd_req=4'b0011, banks {1,0} (agents 1,0) -> rd_grant=4'b0011; collision=0
//      on the next cycle.
//  T3  4 agents held on bank 2 for 4 cycles -> grants 0,1,2,3 one-hot in order;
//      collision=1 on 3 cycles; coll_count=3.
//  T4  ARB_MODE=0, agents 1 and 3 on bank 0 held for 3 cycles -> agent 1 granted
//      each cycle; coll_agents=4'b1000.
//  T5  rd_bank=5 with NB_BANK=5 -> no grant, no collision.
//  T6  coll_count=16'hFFFF plus a collision -> stays 16'hFFFF. clear_count with a
//      collision in the same cycle -> 0. Without the macro, coll_count=0 throughout.

Source files
------------

// File: rtl/read_bank_arbiter.sv
// read_bank_arbiter
//   Per-bank read arbiter for the multi-bank RAM. Each of NB_RDAGENT read agents
//   targets one bank per cycle. Same-bank collisions are resolved combinationally.
//   ARB_MODE=0 grants the lowest index, and ARB_MODE=1 rotates a per-bank pointer.
//   Losing agents hold their request until they are granted.
//
//   Optional feature macro: READ_ARB_STATS_EN
//     defined   : coll_count is a saturating count of collision cycles, and
//                 clear_count zeroes it.
//     undefined : coll_count is tied to 0 and clear_count is ignored.
//
// Ports
//   aclk         in   clock, rising edge
//   areset       in   asynchronous reset, active-high (also gates rd_grant)
//   rd_req       in   per-agent read request
//   rd_bank      in   agent i bank index at [i*BANK_W +: BANK_W]
//   rd_grant     out  per-agent grant, same cycle as the request
//   collision    out  registered: previous cycle had >=2 requests on one bank
//   coll_agents  out  registered: in-range agents denied in the previous cycle
//   clear_count  in   synchronous clear of coll_count
//   coll_count   out  saturating collision-cycle count
module read_bank_arbiter #(
    parameter int NB_RDAGENT = 4,
    parameter int NB_BANK    = 4,
    parameter int BANK_W     = (NB_BANK > 1) ? $clog2(NB_BANK) : 1,
    parameter int ARB_MODE   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NB_RDAGENT-1:0]        rd_req,
    input  logic [NB_RDAGENT*BANK_W-1:0] rd_bank,
    output logic [NB_RDAGENT-1:0]        rd_grant,
    output logic                         collision,
    output logic [NB_RDAGENT-1:0]        coll_agents,
    input  logic                         clear_count,
    output logic [CNT_W-1:0]             coll_count
);

    localparam int              PTR_W      = (NB_RDAGENT > 1) ? $clog2(NB_RDAGENT) : 1;
    localparam int unsigned     NA         = NB_RDAGENT;
    localparam int unsigned     NBK        = NB_BANK;
    // One extra bit so that NB_BANK itself (e.g. 16 with BANK_W=4) is representable.
    localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W + 1)'(NB_BANK);

    if (NB_RDAGENT < 1 || NB_RDAGENT > 16) begin : g_bad_agents
        $error("read_bank_arbiter: NB_RDAGENT must be 1..16");
    end
    if (NB_BANK < 1 || NB_BANK > 16) begin : g_bad_banks
        $error("read_bank_arbiter: NB_BANK must be 1..16");
    end
    if (ARB_MODE != 0 && ARB_MODE != 1) begin : g_bad_mode
        $error("read_bank_arbiter: ARB_MODE must be 0 or 1");
    end

    logic [NB_BANK-1:0][NB_RDAGENT-1:0] bank_req;   // bank_req[b][i]: agent i requests bank b
    logic [NB_RDAGENT-1:0]              req_ok;     // in-range request
    logic [NB_RDAGENT-1:0]              grant_raw;  // arbitration result before reset gating
    logic [NB_BANK-1:0][PTR_W-1:0]      ptr_q;
    logic [NB_BANK-1:0][PTR_W-1:0]      ptr_d;
    logic                               coll_d;
    logic [BANK_W-1:0]                  bidx;
    logic                               found;
    int unsigned                        start;
    int unsigned                        idx;
    int unsigned                        win;

    // Decode each request into its bank row. Out-of-range banks match no row,
    // so they never compete, get granted or count as collisions.
    always_comb begin
        bank_req = '0;
        req_ok   = '0;
        bidx     = '0;
        for (int unsigned i = 0; i < NA; i++) begin
            bidx = rd_bank[i*BANK_W +: BANK_W];
            if (rd_req[i] && ({1'b0, bidx} < BANK_LIMIT)) begin
                req_ok[i] = 1'b1;
                for (int unsigned b = 0; b < NBK; b++) begin
                    if (bidx == BANK_W'(b)) begin
                        bank_req[b][i] = 1'b1;
                    end
                end
            end
        end
    end

    // Per-bank search. Fixed priority starts at agent 0. Round-robin starts at
    // ptr[b] and wraps. Every further requester seen after the winner marks a collision.
    always_comb begin
        grant_raw = '0;
        ptr_d     = ptr_q;
        coll_d    = 1'b0;
        found     = 1'b0;
        start     = 0;
        idx       = 0;
        win       = 0;
        for (int unsigned b = 0; b < NBK; b++) begin
            found = 1'b0;
            win   = 0;
            start = (ARB_MODE == 1) ? 32'(ptr_q[b]) : 0;
            for (int unsigned k = 0; k < NA; k++) begin
                idx = (start + k) % NA;
                if (bank_req[b][idx]) begin
                    if (!found) begin
                        found          = 1'b1;
                        win            = idx;
                        grant_raw[idx] = 1'b1;
                    end else begin
                        coll_d = 1'b1;
                    end
                end
            end
            if (found && (ARB_MODE == 1)) begin
                ptr_d[b] = PTR_W'((win + 1) % NA);
            end
        end
    end

    // Reset drops grants immediately, without waiting for a clock edge.
    always_comb begin
        rd_grant = areset ? '0 : grant_raw;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ptr_q       <= '0;
            collision   <= 1'b0;
            coll_agents <= '0;
        end else begin
            ptr_q       <= ptr_d;
            collision   <= coll_d;
            coll_agents <= req_ok & ~grant_raw;
        end
    end

`ifdef READ_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Clear takes priority over a same-cycle increment, and the count stops at all-ones.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else if (clear_count) begin
            cnt_q <= '0;
        end else if (coll_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        coll_count = cnt_q;
    end
`else
    logic unused_clear_count;

    always_comb begin
        unused_clear_count = clear_count;
        coll_count         = '0;
    end
`endif

endmodule
